// File: rtl/alu_32.sv
// 32-bit execute-stage ALU: 4-bit opcode, two operands, result registered with 1-cycle latency.
// Define ALU_MUL_EN to add the 32x32 multiply (low word) on opcode C; otherwise C reads as reserved.
module alu_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_NOR   = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;

  logic [4:0]  shamt;
  logic [31:0] result_next;

  assign shamt = b[4:0];

  always_comb begin
    result_next = 32'h0;
    case (alu_op)
      OP_ADD:   result_next = a + b;
      OP_SUB:   result_next = a - b;
      OP_AND:   result_next = a & b;
      OP_OR:    result_next = a | b;
      OP_XOR:   result_next = a ^ b;
      OP_SLL:   result_next = a << shamt;
      OP_SRL:   result_next = a >> shamt;
      OP_SRA:   result_next = $unsigned($signed(a) >>> shamt);
      OP_SLT:   result_next = {31'h0, $signed(a) < $signed(b)};
      OP_SLTU:  result_next = {31'h0, a < b};
      OP_NOR:   result_next = ~(a | b);
      OP_PASSB: result_next = b;
`ifdef ALU_MUL_EN
      OP_MUL:   result_next = a * b;
`else
      OP_MUL:   result_next = 32'h0;
`endif
      default:  result_next = 32'h0;
    endcase
  end

  // Loads every cycle; an operation in flight when reset drops is discarded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result <= 32'h0;
    end else begin
      result <= result_next;
    end
  end

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32; opcode C expectations follow ALU_MUL_EN.
module tb_alu_32;

  logic        clock;
  logic        reset;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  alu_32 dut (
    .clock  (clock),
    .reset  (reset),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the capturing rising edge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] expected);
    @(negedge clock);
    alu_op = op;
    a      = va;
    b      = vb;
    @(posedge clock);
    #1;
    check(tag, result, expected);
  endtask

  initial begin
    reset  = 1'b0;
    alu_op = 4'h0;
    a      = 32'hFFFF_FFFF;
    b      = 32'h0000_0001;

    #2;
    check("reset_async", result, 32'h0);
    @(posedge clock);
    #1;
    check("reset_held_edge", result, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("first_capture_wrap", result, 32'h0);

    run_op("add",          4'h0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008);
    run_op("add_ovf",      4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    run_op("sub_neg",      4'h1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE);
    run_op("and",          4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    run_op("or",           4'h3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    run_op("xor",          4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    run_op("sll_31",       4'h5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
    run_op("sll_hi_b_ign", 4'h5, 32'h0000_000F, 32'hFFFF_FFE4, 32'h0000_00F0);
    run_op("sra_4",        4'h7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    run_op("srl_4",        4'h6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    run_op("sra_0",        4'h7, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001);
    run_op("srl_0",        4'h6, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001);
    run_op("slt_neg",      4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    run_op("sltu_big",     4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    run_op("slt_pos",      4'h8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("sltu_small",   4'h9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("slt_equal",    4'h8, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
    run_op("nor",          4'hA, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000);
    run_op("passb",        4'hB, 32'hDEAD_BEEF, 32'hABCD_0000, 32'hABCD_0000);
`ifdef ALU_MUL_EN
    run_op("mul_wrap",     4'hC, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_op("mul_small",    4'hC, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A);
    run_op("mul_ffff",     4'hC, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
`else
    run_op("mul_off",      4'hC, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000);
`endif
    run_op("rsvd_d",       4'hD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);
    run_op("rsvd_e",       4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("rsvd_f",       4'hF, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000);

    // Back-to-back stream: new inputs right after each edge, results one edge later.
    @(negedge clock);
    alu_op = 4'h0; a = 32'h0000_0001; b = 32'h0000_0002;
    @(posedge clock);
    #1;
    check("stream_add", result, 32'h0000_0003);
    alu_op = 4'h4; a = 32'hFF00_FF00; b = 32'h0FF0_0FF0;
    #1;
    check("stream_hold", result, 32'h0000_0003);
    @(posedge clock);
    #1;
    check("stream_xor", result, 32'hF0F0_F0F0);
    alu_op = 4'hA; a = 32'h0000_0000; b = 32'h0000_0000;
    @(posedge clock);
    #1;
    check("stream_nor", result, 32'hFFFF_FFFF);

    // Mid-stream reset: clears immediately, pending op is not replayed.
    alu_op = 4'h0; a = 32'h0000_0010; b = 32'h0000_0010;
    #2;
    reset = 1'b0;
    #1;
    check("midreset_async", result, 32'h0);
    @(posedge clock);
    #1;
    check("midreset_held", result, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_release", result, 32'h0);
    run_op("after_reset", 4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
